// File: rtl/rtc_apb_pkg.sv
// Shared types for the RTC APB requester: FSM state encoding and the
// command/response records exchanged at the default 32-bit widths.
package rtc_apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

    // Width of the ACCESS wait counter: enough to hold timeout_cycles, never below 1 bit.
    function automatic int wait_cnt_width(input int timeout_cycles);
        int w;
        w = (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rtc_apb_master.sv
// Single-outstanding APB requester: one request in, one SETUP/ACCESS
// transfer out, one response back, with an optional PREADY timeout.
module rtc_apb_master
    import rtc_apb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              CLK_APB,
    input  logic              rstn_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic [DATA_W-1:0] PRDATA
);

    localparam int               CNT_W    = wait_cnt_width(TIMEOUT_CYCLES);
    // Counter value at which one more stalled edge exhausts the timeout.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    apb_state_e        state_reg, state_next;
    logic              cmd_write_reg, cmd_write_next;
    logic [ADDR_W-1:0] cmd_addr_reg, cmd_addr_next;
    logic [DATA_W-1:0] cmd_wdata_reg, cmd_wdata_next;
    logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic              rsp_err_reg, rsp_err_next;
    logic              rsp_timeout_reg, rsp_timeout_next;
    logic              apb_active;

    // State, command and response registers; reset drops any transfer in flight.
    always_ff @(posedge CLK_APB or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg       <= IDLE;
            cmd_write_reg   <= 1'b0;
            cmd_addr_reg    <= '0;
            cmd_wdata_reg   <= '0;
            wait_cnt_reg    <= '0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cmd_write_reg   <= cmd_write_next;
            cmd_addr_reg    <= cmd_addr_next;
            cmd_wdata_reg   <= cmd_wdata_next;
            wait_cnt_reg    <= wait_cnt_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_err_reg     <= rsp_err_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    // Next-state logic: accept, run SETUP/ACCESS, capture the result, hand it back.
    always_comb begin
        state_next       = state_reg;
        cmd_write_next   = cmd_write_reg;
        cmd_addr_next    = cmd_addr_reg;
        cmd_wdata_next   = cmd_wdata_reg;
        wait_cnt_next    = wait_cnt_reg;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_err_next     = rsp_err_reg;
        rsp_timeout_next = rsp_timeout_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid_i) begin
                    cmd_write_next = req_write_i;
                    cmd_addr_next  = req_addr_i;
                    // Reads store zero so PWDATA is zero without extra muxing later.
                    cmd_wdata_next = req_write_i ? req_wdata_i : '0;
                    wait_cnt_next  = '0;
                    state_next     = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                // PREADY is tested first so a completion on the expiry edge wins.
                if (PREADY) begin
                    rsp_rdata_next   = (!cmd_write_reg && !PSLVERR) ? PRDATA : '0;
                    rsp_err_next     = PSLVERR;
                    rsp_timeout_next = 1'b0;
                    state_next       = RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                    if ((TIMEOUT_CYCLES != 0) && (wait_cnt_reg == CNT_LAST)) begin
                        rsp_rdata_next   = '0;
                        rsp_err_next     = 1'b1;
                        rsp_timeout_next = 1'b1;
                        state_next       = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_rdata_next   = '0;
                    rsp_err_next     = 1'b0;
                    rsp_timeout_next = 1'b0;
                    state_next       = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign apb_active    = (state_reg == SETUP) || (state_reg == ACCESS);
    assign req_ready_o   = (state_reg == IDLE);
    assign rsp_valid_o   = (state_reg == RESP);
    assign rsp_rdata_o   = rsp_rdata_reg;
    assign rsp_err_o     = rsp_err_reg;
    assign rsp_timeout_o = rsp_timeout_reg;
    assign PSEL          = apb_active;
    assign PENABLE       = (state_reg == ACCESS);
    assign PWRITE        = apb_active & cmd_write_reg;
    assign PADDR         = apb_active ? cmd_addr_reg : '0;
    assign PWDATA        = apb_active ? cmd_wdata_reg : '0;

endmodule

// File: tb/tb_rtc_apb_master.sv
// Directed bench for rtc_apb_master: a transaction-level model predicts the
// bus phase of every cycle and each response; a memory-backed responder
// answers with programmable wait states and errors.
module tb_rtc_apb_master;
    import rtc_apb_pkg::*;

    localparam int TO = 4;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus-side knobs describing how the responder treats the next command.
    int stim_waits = 0;
    bit stim_err   = 1'b0;

    // Model state.
    logic [31:0] mem [logic [31:0]];
    bit          busy      = 1'b0;
    bit          last_idle = 1'b1;
    int          k         = 0;
    int          acc_len   = 0;
    int          cur_w     = 0;
    bit          cur_err   = 1'b0;
    bit          cur_write = 1'b0;
    logic [31:0] cur_addr  = '0;
    logic [31:0] cur_wdata = '0;
    logic [31:0] exp_rdata = '0;
    bit          exp_err   = 1'b0;
    bit          exp_to    = 1'b0;

    rtc_apb_master #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK_APB      (clk),
        .rstn_i       (rstn),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .rsp_timeout_o(rsp_timeout),
        .PSEL         (psel),
        .PENABLE      (penable),
        .PWRITE       (pwrite),
        .PADDR        (paddr),
        .PWDATA       (pwdata),
        .PREADY       (pready),
        .PSLVERR      (pslverr),
        .PRDATA       (prdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Per-cycle model, output comparison and responder, all on the falling edge.
    always @(negedge clk) begin
        int  ph;
        bit  e_sel;
        bit  tmo;
        if (!rstn) begin
            busy      = 1'b0;
            last_idle = 1'b1;
            k         = 0;
            check("rst_req_ready", 64'(req_ready), 64'd1);
            check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
            check("rst_rsp_err",   64'(rsp_err),   64'd0);
            check("rst_rsp_to",    64'(rsp_timeout), 64'd0);
            check("rst_psel",      64'(psel),      64'd0);
            check("rst_penable",   64'(penable),   64'd0);
            check("rst_paddr",     64'(paddr),     64'd0);
            check("rst_pwdata",    64'(pwdata),    64'd0);
            ph = 0;
        end else begin
            // Advance the transaction that was in flight during the previous cycle.
            if (busy && (k >= 2 + acc_len) && rsp_ready) begin
                busy = 1'b0;
            end else if (busy) begin
                k++;
            end
            // A command offered during an idle cycle was taken at the edge just passed.
            if (!busy && last_idle && req_valid) begin
                busy      = 1'b1;
                k         = 1;
                cur_write = req_write;
                cur_addr  = req_addr;
                cur_wdata = req_wdata;
                cur_w     = stim_waits;
                cur_err   = stim_err;
                tmo       = (TO != 0) && (cur_w >= TO);
                acc_len   = tmo ? TO : cur_w + 1;
                exp_err   = tmo || cur_err;
                exp_to    = tmo;
                exp_rdata = (!cur_write && !tmo && !cur_err) ? mem_rd(cur_addr) : 32'h0;
            end
            if (!busy)                 ph = 0;
            else if (k == 1)           ph = 1;
            else if (k <= 1 + acc_len) ph = 2;
            else                       ph = 3;
            // A successful write lands in the responder as the transfer completes.
            if (ph == 3 && k == 2 + acc_len && cur_write && !exp_err) begin
                mem[cur_addr] = cur_wdata;
            end
            e_sel = (ph == 1) || (ph == 2);
            check("req_ready", 64'(req_ready), 64'(ph == 0));
            check("rsp_valid", 64'(rsp_valid), 64'(ph == 3));
            check("psel",      64'(psel),      64'(e_sel));
            check("penable",   64'(penable),   64'(ph == 2));
            check("pwrite",    64'(pwrite),    64'(e_sel && cur_write));
            check("paddr",     64'(paddr),     e_sel ? 64'(cur_addr) : 64'd0);
            check("pwdata",    64'(pwdata),    (e_sel && cur_write) ? 64'(cur_wdata) : 64'd0);
            if (ph == 3) begin
                check("rsp_rdata", 64'(rsp_rdata),   64'(exp_rdata));
                check("rsp_err",   64'(rsp_err),     64'(exp_err));
                check("rsp_to",    64'(rsp_timeout), 64'(exp_to));
            end
            last_idle = (ph == 0);
        end
        // Responder: answers on the planned ACCESS cycle, noise everywhere else.
        if (ph == 2 && (k - 2) == cur_w) begin
            pready  = 1'b1;
            pslverr = cur_err;
            prdata  = cur_err ? 32'h0 : (cur_write ? $urandom : mem_rd(cur_addr));
        end else if (ph == 2) begin
            pready  = 1'b0;
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
        end else begin
            pready  = 1'($urandom_range(0, 1));
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
        end
    end

    // One command end to end, with hand-computed latency and response fields.
    task automatic do_xfer(input apb_req_t rq, input int waits, input bit err, input int stall,
                           input int exp_lat, input logic [31:0] e_rdata, input bit e_err, input bit e_to);
        int lat;
        bit got;
        @(negedge clk);
        #1;
        stim_waits = waits;
        stim_err   = err;
        req_write  = rq.write;
        req_addr   = rq.addr;
        req_wdata  = rq.wdata;
        req_valid  = 1'b1;
        got = 1'b0;
        for (lat = 1; lat <= 40; lat++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (lat == 1) begin
                #1 req_valid = 1'b0;
            end
        end
        check("rsp_arrived", 64'(got),         64'd1);
        check("latency",     64'(lat),         64'(exp_lat));
        check("lit_rdata",   64'(rsp_rdata),   64'(e_rdata));
        check("lit_err",     64'(rsp_err),     64'(e_err));
        check("lit_timeout", 64'(rsp_timeout), 64'(e_to));
        $display("xfer %s addr=%08h wdata=%08h waits=%0d slverr=%0d -> lat=%0d rdata=%08h err=%0d timeout=%0d",
                 rq.write ? "WR" : "RD", rq.addr, rq.wdata, waits, err, lat, rsp_rdata, rsp_err, rsp_timeout);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (stall) @(negedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;
        repeat (3) @(negedge clk);
        check("init_req_ready", 64'(req_ready), 64'd1);
        check("init_psel",      64'(psel),      64'd0);
        #1 rstn = 1'b1;

        //       {write, addr, wdata}                 waits err stall lat rdata          err to
        do_xfer('{1'b1, 32'h10, 32'h1},                 0, 0, 0, 3, 32'h0,         0, 0);
        do_xfer('{1'b0, 32'h10, 32'h0},                 0, 0, 0, 3, 32'h1,         0, 0);
        do_xfer('{1'b1, 32'h14, 32'hA5A5_5A5A},         3, 0, 0, 6, 32'h0,         0, 0);
        do_xfer('{1'b0, 32'h14, 32'h0},                 2, 0, 1, 5, 32'hA5A5_5A5A, 0, 0);
        do_xfer('{1'b0, 32'h10, 32'h0},                99, 0, 0, 6, 32'h0,         1, 1);
        do_xfer('{1'b1, 32'h18, 32'hDEAD_BEEF},        99, 0, 0, 6, 32'h0,         1, 1);
        do_xfer('{1'b0, 32'hFFFF_FFFF, 32'h0},          0, 1, 5, 3, 32'h0,         1, 0);
        do_xfer('{1'b0, 32'h18, 32'h0},                 1, 0, 0, 4, 32'h0,         0, 0);

        // Reset pulsed while the transfer sits in ACCESS.
        @(negedge clk);
        #1;
        stim_waits = 99;
        stim_err   = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h20;
        req_valid  = 1'b1;
        @(negedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("mid_penable", 64'(penable), 64'd1);
        #1 rstn = 1'b0;
        #1;
        check("async_psel",      64'(psel),      64'd0);
        check("async_penable",   64'(penable),   64'd0);
        check("async_paddr",     64'(paddr),     64'd0);
        check("async_req_ready", 64'(req_ready), 64'd1);
        check("async_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        #1 rstn = 1'b1;
        do_xfer('{1'b0, 32'h10, 32'h0},                 0, 0, 0, 3, 32'h1,         0, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rtc_apb_master.md
# rtc_apb_master

APB requester for the RTC subsystem. It accepts single register-access commands on a valid/ready request port and runs each one as a standard two-phase APB transfer (SETUP, then ACCESS) against `rtc_top` or any APB responder. It returns read data and error status on a valid/ready response port. A programmable timeout aborts transfers whose responder never asserts PREADY.

## Interface

Parameters:
- `ADDR_W`, default 32: PADDR / request address width.
- `DATA_W`, default 32: PWDATA / PRDATA / request and response data width.
- `TIMEOUT_CYCLES`, default 16: maximum ACCESS cycles with PREADY low before the transfer is aborted; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-low):
- `CLK_APB`  in  1: sole clock; all state changes on the rising edge.
- `rstn_i`  in  1: asynchronous active-low reset.
- `req_valid_i`  in  1: command present.
- `req_ready_o`  out  1: command accepted when both `req_valid_i` and `req_ready_o` are high.
- `req_write_i`  in  1: 1 = write, 0 = read.
- `req_addr_i`  in  ADDR_W: target address.
- `req_wdata_i`  in  DATA_W: write data; ignored for reads.
- `rsp_valid_o`  out  1: response present.
- `rsp_ready_i`  in  1: response consumed when both `rsp_valid_o` and `rsp_ready_i` are high.
- `rsp_rdata_o`  out  DATA_W: read data; 0 for writes, errors and timeouts.
- `rsp_err_o`  out  1: PSLVERR was sampled high, or a timeout occurred.
- `rsp_timeout_o`  out  1: transfer was aborted by the timeout.
- `PSEL`, `PENABLE`, `PWRITE`  out  1: APB control.
- `PADDR`  out  ADDR_W: APB address.
- `PWDATA`  out  DATA_W: APB write data.
- `PREADY`, `PSLVERR`  in  1: APB responder status.
- `PRDATA`  in  DATA_W: APB read data.

## Operation

- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - `req_ready_o`=1.
  - On handshake, latch write, addr and wdata into a command register and go to SETUP.
- SETUP:
  - PSEL=1, PENABLE=0.
  - PADDR, PWRITE and PWDATA come from the command register. PWDATA=0 for reads.
  - Always lasts exactly 1 cycle, then ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1. PADDR, PWRITE and PWDATA are held stable.
  - At a rising edge with PREADY=1:
    - capture `rsp_rdata_o` = PRDATA for a read, else 0;
    - capture `rsp_err_o` = PSLVERR and `rsp_timeout_o`=0;
    - go to RESP.
  - Each edge with PREADY=0 increments the wait counter. When TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES, go to RESP with rdata=0, err=1, timeout=1.
  - The wait counter is cleared on entry to SETUP and is $clog2(TIMEOUT_CYCLES+1) bits wide, with a minimum of 1 bit.
- RESP:
  - `rsp_valid_o`=1. APB outputs are idle.
  - Response fields are held until the `rsp_ready_i` handshake, then return to IDLE.
- Idle APB values (in IDLE and RESP): PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0.
- Only one transfer is outstanding at a time. `req_ready_o`=0 in every state except IDLE.

## Timing

- Reset values: `req_ready_o`=1; `rsp_valid_o`, `rsp_rdata_o`, `rsp_err_o`, `rsp_timeout_o`=0; all APB outputs 0.
- Zero-wait responder: request accept edge T → SETUP during cycle T+1 → ACCESS during T+2 → `rsp_valid_o` high from T+3.
- With N wait states, `rsp_valid_o` rises N cycles later. A timeout raises `rsp_valid_o` TIMEOUT_CYCLES cycles after ACCESS begins.
- Minimum spacing between back-to-back accepts is 4 cycles: RESP handshake edge → IDLE → next accept.
- PRDATA and PSLVERR are sampled only in ACCESS with PREADY=1. They are ignored at all other times.
- A PREADY that arrives at the same edge the timeout expires counts as a normal completion; PREADY wins.
- Reset asserted mid-transfer: outputs return to their reset values immediately (asynchronously), and the command is dropped with no response.

## Structure

- Add to `rtc_apb_pkg`:
  - the `apb_state_e` enum (IDLE, SETUP, ACCESS, RESP);
  - the `apb_req_t` struct (write, addr, wdata);
  - the `apb_rsp_t` struct (rdata, err, timeout).
- Single module; no sub-module is needed.

## Test plan

- Write addr 32'h10 with data 32'h1 to `rtc_top` (PREADY=1 immediately) → PSEL rises 1 cycle after accept, PENABLE rises 1 cycle after PSEL, `rsp_valid_o` at T+3 with err=0 and rdata=0.
- Read of the same address after that write → `rsp_rdata_o`=32'h1, err=0; PWDATA=0 throughout.
- Responder holds PREADY low for 3 cycles, with TIMEOUT_CYCLES=16 → ACCESS lasts 4 cycles with PADDR/PWDATA stable; normal response.
- PREADY never rises, with TIMEOUT_CYCLES=4 → after 4 ACCESS cycles, err=1, timeout=1, rdata=0; PSEL drops.
- Read of 32'hFFFF_FFFF where the responder returns PSLVERR=1 → err=1, timeout=0; `rsp_valid_o` holds while `rsp_ready_i`=0 for 5 cycles; `req_ready_o` stays 0 until the handshake.
- Reset pulsed during ACCESS → all outputs at reset values at once, `req_ready_o`=1 after release, and the next command completes normally.
